floppy_sdram_prefetch: RTL and testbench

//   Read-ahead line buffer between floppy sdram port (sdram_addr/_data/_read/_write/_busy)
//   and sdram_arbitre disk byte port. Read misses fetch LINE_BYTES sequential bytes; later

---
 rtl/floppy_sdram_prefetch.sv | 222 ++++++++++++++++++++++
 tb/tb_floppy_sdram_prefetch.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/floppy_sdram_prefetch.sv
// floppy_sdram_prefetch
//   Read-ahead line buffer between the floppy SDRAM byte port and the
//   arbiter disk byte port. A read miss fetches a whole line of
//   LINE_BYTES sequential bytes, one arbiter transaction per byte.
//   Later reads that fall inside the buffered line return in 2 cycles
//   without touching SDRAM. Writes go straight through to SDRAM; a write
//   that hits the buffered line also updates the buffered byte.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   up_addr/up_di       floppy byte address / write data
//   up_read/up_write    1-cycle request pulses (write wins if both)
//   up_do/up_busy       read data / request in progress (registered)
//   flush               invalidate the buffered line
//   ram_addr/ram_do     arbiter byte address / write data
//   ram_di              arbiter read data
//   ram_read/ram_write  1-cycle arbiter request pulses
//   ram_busy            arbiter busy
`timescale 1ns/1ps
module floppy_sdram_prefetch #(
  parameter int unsigned LINE_LOG2 = 3,
  parameter int unsigned ADDR_W    = 23
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic [7:0]        up_di,
  output logic [7:0]        up_do,
  input  logic              up_read,
  input  logic              up_write,
  output logic              up_busy,
  input  logic              flush,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_do,
  input  logic [7:0]        ram_di,
  output logic              ram_read,
  output logic              ram_write,
  input  logic              ram_busy
);

  localparam int unsigned LINE_BYTES = 1 << LINE_LOG2;
  localparam int unsigned TAG_W      = ADDR_W - LINE_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HIT,
    S_FILL_REQ,
    S_FILL_WAIT_HI,
    S_FILL_WAIT_LO,
    S_WR_REQ,
    S_WR_WAIT_HI,
    S_WR_WAIT_LO
  } state_t;

  state_t               state_q, state_d;
  logic                 valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q, tag_d;
  logic [LINE_LOG2-1:0] idx_q, idx_d;
  logic [LINE_LOG2-1:0] off_q, off_d;
  logic                 flushed_q, flushed_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic [7:0]           line_q [LINE_BYTES];
  logic [7:0]           line_d [LINE_BYTES];
  logic [7:0]           up_do_q, up_do_d;
  logic                 up_busy_q, up_busy_d;
  logic [ADDR_W-1:0]    ram_addr_q, ram_addr_d;
  logic [7:0]           ram_do_q, ram_do_d;
  logic                 ram_read_q, ram_read_d;
  logic                 ram_write_q, ram_write_d;

  logic [TAG_W-1:0]     req_tag;
  logic [LINE_LOG2-1:0] req_off;
  logic                 hit;
  logic [7:0]           fill_byte;

  assign req_tag = up_addr[ADDR_W-1:LINE_LOG2];
  assign req_off = up_addr[LINE_LOG2-1:0];
  assign hit     = valid_q && (req_tag == tag_q);

  // The requested byte may be the one arriving on ram_di in the final fill
  // cycle, before it has been written into the line registers.
  assign fill_byte = (off_q == idx_q) ? ram_di : line_q[off_q];

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    idx_d       = idx_q;
    off_d       = off_q;
    flushed_d   = flushed_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    line_d      = line_q;
    up_do_d     = up_do_q;
    up_busy_d   = up_busy_q;
    ram_addr_d  = ram_addr_q;
    ram_do_d    = ram_do_q;
    ram_read_d  = 1'b0;
    ram_write_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!up_busy_q) begin
          if (up_write) begin
            wr_addr_d = up_addr;
            wr_data_d = up_di;
            up_busy_d = 1'b1;
            if (hit) line_d[req_off] = up_di;
            state_d = S_WR_REQ;
          end else if (up_read) begin
            up_busy_d = 1'b1;
            off_d     = req_off;
            if (hit) begin
              state_d = S_HIT;
            end else begin
              valid_d   = 1'b0;
              tag_d     = req_tag;
              idx_d     = '0;
              flushed_d = 1'b0;
              state_d   = S_FILL_REQ;
            end
          end
        end
      end
      S_HIT: begin
        up_do_d   = line_q[off_q];
        up_busy_d = 1'b0;
        state_d   = S_IDLE;
      end
      S_FILL_REQ: begin
        ram_addr_d = {tag_q, idx_q};
        ram_read_d = 1'b1;
        state_d    = S_FILL_WAIT_HI;
      end
      S_FILL_WAIT_HI: begin
        if (ram_busy) state_d = S_FILL_WAIT_LO;
      end
      S_FILL_WAIT_LO: begin
        if (!ram_busy) begin
          line_d[idx_q] = ram_di;
          if (idx_q == '1) begin
            valid_d   = !flushed_q;
            up_do_d   = fill_byte;
            up_busy_d = 1'b0;
            state_d   = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FILL_REQ;
          end
        end
      end
      S_WR_REQ: begin
        ram_addr_d  = wr_addr_q;
        ram_do_d    = wr_data_q;
        ram_write_d = 1'b1;
        state_d     = S_WR_WAIT_HI;
      end
      S_WR_WAIT_HI: begin
        if (ram_busy) state_d = S_WR_WAIT_LO;
      end
      S_WR_WAIT_LO: begin
        if (!ram_busy) begin
          up_busy_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flush overrides everything: a fill in flight still completes and
    // returns its byte, but the line it leaves behind is not trusted.
    if (flush) begin
      valid_d   = 1'b0;
      flushed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      valid_q     <= 1'b0;
      tag_q       <= '0;
      idx_q       <= '0;
      off_q       <= '0;
      flushed_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int unsigned i = 0; i < LINE_BYTES; i++) line_q[i] <= '0;
      up_do_q     <= '0;
      up_busy_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_do_q    <= '0;
      ram_read_q  <= 1'b0;
      ram_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      idx_q       <= idx_d;
      off_q       <= off_d;
      flushed_q   <= flushed_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      line_q      <= line_d;
      up_do_q     <= up_do_d;
      up_busy_q   <= up_busy_d;
      ram_addr_q  <= ram_addr_d;
      ram_do_q    <= ram_do_d;
      ram_read_q  <= ram_read_d;
      ram_write_q <= ram_write_d;
    end
  end

  assign up_do     = up_do_q;
  assign up_busy   = up_busy_q;
  assign ram_addr  = ram_addr_q;
  assign ram_do    = ram_do_q;
  assign ram_read  = ram_read_q;
  assign ram_write = ram_write_q;

endmodule

// File: tb/tb_floppy_sdram_prefetch.sv
`timescale 1ns/1ps
module tb_floppy_sdram_prefetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [22:0] up_addr;
  logic [7:0]  up_di;
  logic [7:0]  up_do;
  logic        up_read;
  logic        up_write;
  logic        up_busy;
  logic        flush;
  logic [22:0] ram_addr;
  logic [7:0]  ram_do;
  logic [7:0]  ram_di;
  logic        ram_read;
  logic        ram_write;
  logic        ram_busy;

  int checks = 0;
  int errors = 0;
  int proto_err = 0;

  logic [7:0]  mem [256];
  logic [22:0] rd_log[$];
  logic [22:0] wr_addr_log[$];
  logic [7:0]  wr_data_log[$];

  always #5 clk = ~clk;

  floppy_sdram_prefetch #(.LINE_LOG2(3), .ADDR_W(23)) dut (
    .clk(clk), .reset_n(reset_n),
    .up_addr(up_addr), .up_di(up_di), .up_do(up_do),
    .up_read(up_read), .up_write(up_write), .up_busy(up_busy),
    .flush(flush),
    .ram_addr(ram_addr), .ram_do(ram_do), .ram_di(ram_di),
    .ram_read(ram_read), .ram_write(ram_write), .ram_busy(ram_busy)
  );

  // SDRAM arbiter model: busy rises the cycle after a pulse, stays high two
  // cycles, read data is presented as busy falls. Byte content = mem[addr[7:0]].
  initial begin : sdram_model
    logic [7:0] pend;
    ram_busy = 1'b0;
    ram_di   = 8'h00;
    pend     = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    forever begin
      @(posedge clk); #1;
      if (ram_read === 1'b1 || ram_write === 1'b1) begin
        if (ram_read === 1'b1 && ram_write === 1'b1) proto_err++;
        if (ram_read === 1'b1) begin
          rd_log.push_back(ram_addr);
          pend = mem[ram_addr[7:0]];
        end else begin
          wr_addr_log.push_back(ram_addr);
          wr_data_log.push_back(ram_do);
          mem[ram_addr[7:0]] = ram_do;
        end
        @(posedge clk); #1;
        if (ram_read === 1'b1 || ram_write === 1'b1) proto_err++;
        ram_busy = 1'b1;
        repeat (2) begin
          @(posedge clk); #1;
          if (ram_read === 1'b1 || ram_write === 1'b1) proto_err++;
        end
        ram_di   = pend;
        ram_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read request; exp_reads==0 means a hit (also checks 1-cycle busy).
  // fa>=0 pulses flush once that many fill reads have been issued.
  // stray issues a write attempt while busy, which must be ignored.
  task automatic do_read(input logic [22:0] a, input logic [7:0] exp_do,
                         input int exp_reads, input logic [22:0] exp_first,
                         input int fa, input bit stray, input string tag);
    int n0, w0, cyc;
    bit done;
    n0 = rd_log.size();
    w0 = wr_addr_log.size();
    done = 1'b0;
    cyc = 0;
    up_addr = a;
    up_read = 1'b1;
    @(posedge clk); #2;
    up_read = 1'b0;
    chk({tag, " busy_rise"}, 32'(up_busy), 32'd1);
    if (stray) begin
      up_write = 1'b1;
      up_addr  = 23'h60;
      up_di    = 8'h66;
      @(posedge clk); #2;
      up_write = 1'b0;
      cyc = 1;
    end
    while (up_busy === 1'b1 && cyc < 300) begin
      @(posedge clk); #2;
      flush = 1'b0;
      cyc++;
      if (fa >= 0 && !done && (rd_log.size() - n0) >= fa) begin
        flush = 1'b1;
        done  = 1'b1;
      end
    end
    if (flush) begin
      @(posedge clk); #2;
      flush = 1'b0;
    end
    chk({tag, " busy_fall"}, 32'(up_busy), 32'd0);
    chk({tag, " data"}, 32'(up_do), 32'(exp_do));
    chk({tag, " nreads"}, 32'(rd_log.size() - n0), 32'(exp_reads));
    chk({tag, " nwrites"}, 32'(wr_addr_log.size() - w0), 32'd0);
    if (exp_reads == 0) chk({tag, " hit_latency"}, 32'(cyc), 32'd1);
    for (int i = 0; i < exp_reads && (n0 + i) < rd_log.size(); i++)
      chk({tag, " fill_addr"}, 32'(rd_log[n0 + i]), 32'(exp_first + 23'(i)));
  endtask

  task automatic do_write(input logic [22:0] a, input logic [7:0] d,
                          input bit also_read, input string tag);
    int n0, w0, cyc;
    n0 = rd_log.size();
    w0 = wr_addr_log.size();
    cyc = 0;
    up_addr  = a;
    up_di    = d;
    up_write = 1'b1;
    up_read  = also_read;
    @(posedge clk); #2;
    up_write = 1'b0;
    up_read  = 1'b0;
    chk({tag, " busy_rise"}, 32'(up_busy), 32'd1);
    while (up_busy === 1'b1 && cyc < 300) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk({tag, " busy_fall"}, 32'(up_busy), 32'd0);
    chk({tag, " nwrites"}, 32'(wr_addr_log.size() - w0), 32'd1);
    chk({tag, " nreads"}, 32'(rd_log.size() - n0), 32'd0);
    if (wr_addr_log.size() > w0) begin
      chk({tag, " waddr"}, 32'(wr_addr_log[w0]), 32'(a));
      chk({tag, " wdata"}, 32'(wr_data_log[w0]), 32'(d));
    end
  endtask

  initial begin : stim
    int cyc;
    reset_n  = 1'b0;
    up_addr  = '0;
    up_di    = '0;
    up_read  = 1'b0;
    up_write = 1'b0;
    flush    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst up_do", 32'(up_do), 32'd0);
    chk("rst up_busy", 32'(up_busy), 32'd0);
    chk("rst ram_addr", 32'(ram_addr), 32'd0);
    chk("rst ram_do", 32'(ram_do), 32'd0);
    chk("rst ram_read", 32'(ram_read), 32'd0);
    chk("rst ram_write", 32'(ram_write), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #2;

    // Cold miss, then hits across the rest of the line
    do_read(23'h10, 8'h10, 8, 23'h10, -1, 1'b0, "miss10");
    for (int i = 1; i < 8; i++)
      do_read(23'h10 + 23'(i), 8'(8'h10 + i), 0, 23'h0, -1, 1'b0, "hit1x");
    // Line crossing and single-line replacement
    do_read(23'h18, 8'h18, 8, 23'h18, -1, 1'b0, "miss18");
    do_read(23'h10, 8'h10, 8, 23'h10, -1, 1'b0, "refill10");

    // Write-through hit updates buffer; write miss leaves the line alone
    do_write(23'h12, 8'hA5, 1'b0, "wr12");
    do_read(23'h12, 8'hA5, 0, 23'h0, -1, 1'b0, "hit12");
    do_write(23'h40, 8'h5C, 1'b0, "wr40");
    do_read(23'h11, 8'h11, 0, 23'h0, -1, 1'b0, "hit11");
    // Read and write together: write wins, no fill
    do_write(23'h70, 8'h33, 1'b1, "rdwr70");
    do_read(23'h14, 8'h14, 0, 23'h0, -1, 1'b0, "hit14");

    // Flush mid-fill: data still returned, line left invalid
    do_read(23'h20, 8'h20, 8, 23'h20, 3, 1'b0, "flushfill20");
    do_read(23'h21, 8'h21, 8, 23'h20, -1, 1'b0, "refill21");

    // Requested byte is the last one fetched
    do_read(23'h3F, 8'h3F, 8, 23'h38, -1, 1'b0, "miss3f");
    do_read(23'h3C, 8'h3C, 0, 23'h0, -1, 1'b0, "hit3c");

    // Top-of-memory line, with an ignored write attempt while busy
    do_read(23'h7FFFFF, 8'hFF, 8, 23'h7FFFF8, -1, 1'b1, "wraptop");
    do_read(23'h7FFFF8, 8'hF8, 0, 23'h0, -1, 1'b0, "hittop");

    // Reset while waiting for a fill byte
    up_addr = 23'h50;
    up_read = 1'b1;
    @(posedge clk); #2;
    up_read = 1'b0;
    cyc = 0;
    while (ram_busy !== 1'b1 && cyc < 100) begin
      @(posedge clk); #2;
      cyc++;
    end
    chk("midfill ram_busy_seen", 32'(ram_busy), 32'd1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("arst up_do", 32'(up_do), 32'd0);
    chk("arst up_busy", 32'(up_busy), 32'd0);
    chk("arst ram_addr", 32'(ram_addr), 32'd0);
    chk("arst ram_do", 32'(ram_do), 32'd0);
    chk("arst ram_read", 32'(ram_read), 32'd0);
    chk("arst ram_write", 32'(ram_write), 32'd0);
    cyc = 0;
    while (ram_busy !== 1'b0 && cyc < 100) begin
      @(posedge clk); #2;
      cyc++;
    end
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk); #2;
    do_read(23'h13, 8'h13, 8, 23'h10, -1, 1'b0, "postrst13");
    do_read(23'h12, 8'hA5, 0, 23'h0, -1, 1'b0, "postrst12");

    // Flush while idle forces a refill
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    do_read(23'h12, 8'hA5, 8, 23'h10, -1, 1'b0, "idleflush12");

    chk("protocol", 32'(proto_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
